// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Pure declarations; no logic, no latency, no flow control.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ctrl_state_t;

    localparam int DIV_MIN = 2;

    function automatic int unsigned half_ceil(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: phase counter, registered clk_p and optional negedge clk_n stage.
// Wrap strobe is combinational from the count; CLK_DIV_DUTY50_EN adds the negedge stage. No backpressure.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cur_div,
    output logic             wrap,
    output logic [CNT_W-1:0] pos_count,
    output logic             clk_out
);

    logic [CNT_W-1:0] r_pos_count;
    logic             r_clk_p;
    logic [CNT_W-1:0] w_half;
    logic             w_wrap;

    assign w_half = CNT_W'(half_ceil(32'(cur_div)));
    assign w_wrap = (r_pos_count == cur_div - CNT_W'(1));

    // clk_p is sampled from the pre-update count, so it is always low on the wrap edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_count <= '0;
            r_clk_p     <= 1'b0;
        end else begin
            r_pos_count <= w_wrap ? '0 : r_pos_count + CNT_W'(1);
            r_clk_p     <= (r_pos_count < w_half);
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic r_clk_n;

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_n <= 1'b0;
        end else begin
            r_clk_n <= r_clk_p;
        end
    end

    // Odd ratios trim half a cycle off the high phase by ANDing with the delayed copy.
    assign clk_out = cur_div[0] ? (r_clk_p & r_clk_n) : r_clk_p;
`else
    assign clk_out = r_clk_p;
`endif

    assign wrap      = w_wrap;
    assign pos_count = r_pos_count;

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider; new ratios apply at the next period wrap (ack 1..cur_div cycles after accept).
// A second request while one is pending is dropped; CLK_DIV_DUTY50_EN selects 50% duty for odd ratios.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             period_tick,
    output logic [CNT_W-1:0] pos_count,
    output logic             clk_out
);

    ctrl_state_t      r_state;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_div_ack;
    logic             r_div_err;
    logic             r_period_tick;
    logic             w_wrap;

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cur_div   (r_cur_div),
        .wrap      (w_wrap),
        .pos_count (pos_count),
        .clk_out   (clk_out)
    );

    // A request accepted on a wrap edge is in IDLE there, so it waits for the following wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cur_div     <= CNT_W'(DIV_DEFAULT);
            r_pend_div    <= '0;
            r_div_ack     <= 1'b0;
            r_div_err     <= 1'b0;
            r_period_tick <= 1'b0;
        end else begin
            r_div_ack     <= 1'b0;
            r_div_err     <= 1'b0;
            r_period_tick <= w_wrap;
            case (r_state)
                IDLE: begin
                    if (div_req) begin
                        if (div_val >= CNT_W'(DIV_MIN)) begin
                            r_pend_div <= div_val;
                            r_state    <= PEND;
                        end else begin
                            r_div_err  <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (w_wrap) begin
                        r_cur_div <= r_pend_div;
                        r_div_ack <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state == PEND);
    assign cur_div     = r_cur_div;
    assign div_ack     = r_div_ack;
    assign div_err     = r_div_err;
    assign period_tick = r_period_tick;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl against a period/phase reference model.
module tb_clk_div_ctrl;

    localparam int CNT_W       = 4;
    localparam int DIV_DEFAULT = 3;
`ifdef CLK_DIV_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    logic             clk_in  = 1'b0;
    logic             rst_n   = 1'b0;
    logic             div_req = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_ack;
    logic             div_err;
    logic             busy;
    logic [CNT_W-1:0] cur_div;
    logic             period_tick;
    logic [CNT_W-1:0] pos_count;
    logic             clk_out;

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .div_req     (div_req),
        .div_val     (div_val),
        .div_ack     (div_ack),
        .div_err     (div_err),
        .busy        (busy),
        .cur_div     (cur_div),
        .period_tick (period_tick),
        .pos_count   (pos_count),
        .clk_out     (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles elapsed in the current period, active ratio, optional pending ratio.
    int m_age;
    int m_cur;
    int m_pend_q[$];
    bit m_hi;
    bit m_hi_prev;
    bit e_tick, e_ack, e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age     = 0;
        m_cur     = DIV_DEFAULT;
        m_pend_q  = {};
        m_hi      = 1'b0;
        m_hi_prev = 1'b0;
        e_tick    = 1'b0;
        e_ack     = 1'b0;
        e_err     = 1'b0;
    endtask

    function automatic bit exp_clk_after_pos();
        if (DUTY50 && (m_cur % 2 == 1))
            return m_hi & m_hi_prev;
        return m_hi;
    endfunction

    task automatic check_all(input string pfx);
        check({pfx, "_pos_count"}, pos_count, m_age);
        check({pfx, "_cur_div"}, cur_div, m_cur);
        check({pfx, "_busy"}, busy, (m_pend_q.size() != 0));
        check({pfx, "_ack"}, div_ack, e_ack);
        check({pfx, "_err"}, div_err, e_err);
        check({pfx, "_tick"}, period_tick, e_tick);
        check({pfx, "_clk_out"}, clk_out, exp_clk_after_pos());
    endtask

    task automatic step(input bit req, input int val);
        bit period_end;
        div_req = req;
        div_val = CNT_W'(val);
        @(posedge clk_in);
        // The output is high for the first ceil(N/2) cycles of each period, one cycle late.
        period_end = (m_age == m_cur - 1);
        m_hi_prev  = m_hi;
        m_hi       = (m_age < (m_cur + 1) / 2);
        e_tick     = period_end;
        e_err      = (m_pend_q.size() == 0) && req && (val < 2);
        e_ack      = period_end && (m_pend_q.size() != 0);
        if (e_ack) m_cur = m_pend_q.pop_front();
        else if (m_pend_q.size() == 0 && req && val >= 2) m_pend_q.push_back(val);
        m_age = period_end ? 0 : m_age + 1;
        #1;
        check_all("pos");
        div_req = 1'b0;
        @(negedge clk_in);
        #1;
        check("neg_clk_out", clk_out, m_hi);
    endtask

    initial begin
        model_reset();
        #23;
        check_all("reset");
        @(negedge clk_in);
        #1;
        rst_n = 1'b1;

        repeat (7) step(1'b0, 0);
        step(1'b1, 4);
        repeat (9) step(1'b0, 0);
        step(1'b1, 1);
        repeat (3) step(1'b0, 0);
        step(1'b1, 0);
        step(1'b0, 0);
        step(1'b1, 5);
        step(1'b1, 7);
        repeat (12) step(1'b0, 0);

        // Request landing exactly on a wrap edge must wait a full period.
        for (int i = 0; i < 20 && !(m_age == m_cur - 1 && m_pend_q.size() == 0); i++)
            step(1'b0, 0);
        step(1'b1, 3);
        repeat (12) step(1'b0, 0);

        step(1'b1, 2);
        repeat (6) step(1'b0, 0);
        step(1'b1, 15);
        repeat (36) step(1'b0, 0);

        // Asynchronous reset while a change is pending.
        step(1'b1, 6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
        check_all("arst_hold");
        rst_n = 1'b1;
        repeat (12) step(1'b0, 0);

        step(1'b1, 5);
        repeat (20) step(1'b0, 0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0)
                step(1'b1, int'($urandom_range(0, 15)));
            else
                step(1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
